stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control and timing source for the stopwatch display path. It turns debounced button pulses and the mode switch into the signals the segment-display mux consumes: a running BCD digit, a captured lap digit, an idle-animation phase, a display select, the error flags and the view select. It sits between the button debouncers and the display block, on the same clock.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count increment
ANIM_DIV, 5_000_000, clk cycles per animation phase step
ERR_HOLD, 100_000_000, clk cycles an error flag stays asserted

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start_btn  input  1  single-cycle start pulse (debounced upstream)
stop_btn  input  1  single-cycle stop pulse (debounced upstream)
mode_sw  input  1  view request: 0 = count view, 1 = time/lap view
a  output  4  running BCD digit, 0..9
a_time  output  4  lap digit captured on stop, 0..9
a2  output  3  idle animation phase, 0..6
signal  output  1  1 = show digit a; 0 = show animation a2
error_over_start  output  1  start pressed while already running
error_over_start_time  output  1  start pressed while in time view
error_changing  output  1  view change attempted while running
mood  output  1  registered view select (1 = time view)

Behaviour:
- Clock, reset: one clock (clk). Reset is synchronous and active-high. On reset, all outputs are 0, state = IDLE, and all internal counters are 0.
- States (one-hot or enum): IDLE, RUN, PAUSE. signal = 0 in IDLE, 1 in RUN and PAUSE. signal is registered, so it updates in the same cycle as the state register.
- Transitions, with start_btn and stop_btn sampled on the clock edge:
  - IDLE + start -> RUN.
  - RUN + stop -> PAUSE, and a_time <= a (the current value, before any same-cycle increment).
  - PAUSE + start -> RUN.
  - PAUSE + stop -> IDLE, with a <= 0 and tick_cnt <= 0.
  - IDLE + stop: no effect.
- start_btn and stop_btn high in the same cycle: ignored entirely. No transition and no error.
- Start while mood = 1 (time view): no transition in any state. Sets error_over_start_time. This check takes priority over the RUN + start check.
- Tick counter: counts only in RUN. On reaching TICK_DIV-1 it wraps to 0 and a increments. a wraps from 9 to 0. The counter holds its value in PAUSE, and it is cleared on entering IDLE.
- Animation: anim_cnt and a2 advance only in IDLE. Every ANIM_DIV cycles a2 increments, wrapping from 6 to 0. a2 is 7 states (0..6) and never takes the value 7. Leaving IDLE freezes a2 and anim_cnt. Re-entering IDLE from PAUSE resets a2 to 0.
- mood: follows mode_sw with one cycle of latency, except while in RUN. A mode_sw value differing from mood during RUN leaves mood unchanged and sets error_changing. The error re-triggers each cycle the mismatch persists. Once the FSM leaves RUN, mood catches up on the next cycle.
- RUN + start with mood = 0: stays in RUN and sets error_over_start.
- Error flags:
  - They share one down-counter err_cnt.
  - Any error event sets its own flag and reloads err_cnt = ERR_HOLD-1. Flags already set stay set.
  - All flags clear together on the cycle after err_cnt reaches 0 with no new event.
  - A new event on the same cycle as expiry wins: it reloads the counter and keeps the flags.
- Reset mid-operation: everything returns to the reset values above on the next edge, regardless of state or pending errors.
- Widths: all counters are sized $clog2(param). Comparisons use parameter-1, with no overflow beyond the stated wrap values.

Decomposition:
- Package stopwatch_pkg holds:
  - the state_t enum {IDLE, RUN, PAUSE};
  - localparams DIGIT_MAX = 9 and ANIM_LAST = 6;
  - widths DIGIT_W = 4 and ANIM_W = 3.
- One sub-module is natural: sw_mod_counter.
  - Parameters: MODULUS.
  - Ports: clk, reset, en, clr, count, wrap.
  - Instantiated for tick_cnt/a, anim_cnt/a2, and the digit counters.
- The error hold timer and the FSM stay in stopwatch_ctrl.

Test Plan:
All scenarios run with TICK_DIV = 4, ANIM_DIV = 2, ERR_HOLD = 3.
- Reset and idle animation: hold reset 2 cycles, then release. All outputs are 0. a2 steps 0,1,...,6,0, changing every 2 cycles; signal = 0.
- Run, wrap and lap:
  - Stimulus: start pulse, wait 40 cycles, stop pulse.
  - Response: signal = 1 after start. a increments every 4 cycles and passes through 9 -> 0. On stop, a_time equals a and the state is PAUSE.
  - A second stop returns to IDLE with a = 0.
- Double start:
  - Stimulus: start, then start again 5 cycles later.
  - Response: error_over_start = 1 for exactly 3 cycles. a keeps counting. Other flags stay 0.
  - A third start 1 cycle before expiry extends the flag another 3 cycles.
- Mode change while running:
  - Stimulus: in RUN, raise mode_sw.
  - Response: mood stays 0 and error_changing stays asserted while the mismatch persists.
  - After stop, mood becomes 1 within 1 cycle, and error_changing clears 3 cycles after the last event.
- Start in time view: with mood = 1 in IDLE, a start pulse leaves the state IDLE and gives error_over_start_time = 1 for 3 cycles.
- Simultaneous start+stop and mid-run reset:
  - Both buttons in the same cycle in RUN cause no change and no error.
  - Asserting reset during RUN with a = 7 and error_over_start active gives all outputs 0 on the next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ==========================================================================
// stopwatch_pkg : shared types and constants for the stopwatch control path
// Rev 1.0
// ==========================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DIGIT_MAX = 9;
  localparam int ANIM_LAST = 6;
  localparam int DIGIT_W   = 4;
  localparam int ANIM_W    = 3;

endpackage

`default_nettype wire

// File: rtl/sw_mod_counter.sv
// ==========================================================================
// sw_mod_counter : modulo-N up counter with enable, clear and wrap strobe
// Rev 1.0
// ==========================================================================
`default_nettype none

module sw_mod_counter #(
  parameter int MODULUS = 10,
  parameter int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  // wrap is the carry into the next stage; it only fires on an enabled cycle
  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ==========================================================================
// stopwatch_ctrl : button FSM, BCD/animation timing and error-flag hold
// Rev 1.0
// ==========================================================================
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int ANIM_DIV = 5_000_000,
  parameter int ERR_HOLD = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               stop_btn,
  input  logic               mode_sw,
  output logic [DIGIT_W-1:0] a,
  output logic [DIGIT_W-1:0] a_time,
  output logic [ANIM_W-1:0]  a2,
  output logic               signal,
  output logic               error_over_start,
  output logic               error_over_start_time,
  output logic               error_changing,
  output logic               mood
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ANIM_CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int ERR_W  = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [ERR_W-1:0] ERR_RELOAD = ERR_W'(ERR_HOLD - 1);

  state_t state;
  state_t state_nx;

  logic start_ev;
  logic stop_ev;
  logic ev_os;
  logic ev_ost;
  logic ev_ch;
  logic capture;
  logic enter_idle;

  logic [TICK_W-1:0]  tick_cnt;
  logic [ANIM_CW-1:0] anim_cnt;
  logic               tick_wrap;
  logic               anim_wrap;
  logic               digit_wrap;
  logic               a2_wrap;
  logic [ERR_W-1:0]   err_cnt;
  logic               any_err;
  logic               unused_bits;

  // Simultaneous start+stop is treated as no press at all.
  always_comb begin
    start_ev   = start_btn & ~stop_btn;
    stop_ev    = stop_btn & ~start_btn;
    state_nx   = state;
    ev_os      = 1'b0;
    ev_ost     = 1'b0;
    capture    = 1'b0;
    enter_idle = 1'b0;
    if (start_ev && mood) begin
      ev_ost = 1'b1;
    end else if (start_ev) begin
      case (state)
        IDLE, PAUSE: state_nx = RUN;
        RUN:         ev_os    = 1'b1;
        default:     state_nx = IDLE;
      endcase
    end else if (stop_ev) begin
      case (state)
        RUN: begin
          state_nx = PAUSE;
          capture  = 1'b1;
        end
        PAUSE: begin
          state_nx   = IDLE;
          enter_idle = 1'b1;
        end
        default: state_nx = state;
      endcase
    end
    ev_ch = (state == RUN) && (mode_sw != mood);
  end

  sw_mod_counter #(.MODULUS(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (enter_idle),
    .count (tick_cnt),
    .wrap  (tick_wrap)
  );

  sw_mod_counter #(.MODULUS(DIGIT_MAX + 1)) u_digit (
    .clk   (clk),
    .reset (reset),
    .en    (tick_wrap),
    .clr   (enter_idle),
    .count (a),
    .wrap  (digit_wrap)
  );

  sw_mod_counter #(.MODULUS(ANIM_DIV)) u_anim (
    .clk   (clk),
    .reset (reset),
    .en    (state == IDLE),
    .clr   (enter_idle),
    .count (anim_cnt),
    .wrap  (anim_wrap)
  );

  sw_mod_counter #(.MODULUS(ANIM_LAST + 1)) u_a2 (
    .clk   (clk),
    .reset (reset),
    .en    (anim_wrap),
    .clr   (enter_idle),
    .count (a2),
    .wrap  (a2_wrap)
  );

  assign unused_bits = ^{tick_cnt, anim_cnt, digit_wrap, a2_wrap};
  assign any_err     = error_over_start | error_over_start_time | error_changing;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      signal                <= 1'b0;
      a_time                <= '0;
      mood                  <= 1'b0;
      error_over_start      <= 1'b0;
      error_over_start_time <= 1'b0;
      error_changing        <= 1'b0;
      err_cnt               <= '0;
    end else begin
      state  <= state_nx;
      signal <= (state_nx != IDLE);
      if (capture) begin
        a_time <= a;
      end
      // The view is locked while running; it catches up once RUN is left.
      if (!ev_ch) begin
        mood <= mode_sw;
      end
      // A fresh event always wins over expiry of the shared hold timer.
      if (ev_os || ev_ost || ev_ch) begin
        error_over_start      <= error_over_start | ev_os;
        error_over_start_time <= error_over_start_time | ev_ost;
        error_changing        <= error_changing | ev_ch;
        err_cnt               <= ERR_RELOAD;
      end else if (any_err) begin
        if (err_cnt == '0) begin
          error_over_start      <= 1'b0;
          error_over_start_time <= 1'b0;
          error_changing        <= 1'b0;
        end else begin
          err_cnt <= err_cnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
